// File: rtl/mmio_port_bank.sv
// -----------------------------------------------------------------------------
// mmio_port_bank
//
// Memory-mapped IO port bank for the OTTER IOBUS. It holds N_IN synchronised
// input ports, N_OUT read/write output registers, and change-detect interrupts
// with pending (W1C) and mask registers. It drives one level interrupt (INTR).
//
// Register index = (IOBUS_ADDR - BASE_ADDR) >> STRIDE_LOG2
//   0 .. N_IN-1            input port k (read-only, synchronised value)
//   N_IN .. N_IN+N_OUT-1   output register (R/W)
//   N_IN+N_OUT             IRQ_PEND (read pending, write 1 to clear)
//   N_IN+N_OUT+1           IRQ_MASK (R/W)
//
// Ports:
//   CLK        bus clock, all state on posedge
//   RST_N      asynchronous active-low reset
//   IOBUS_ADDR bus address
//   IOBUS_OUT  write data from MCU
//   IOBUS_WR   single-cycle write strobe
//   IOBUS_IN   combinational read data to MCU (unmapped reads return 0)
//   IN_PORTS   raw asynchronous inputs, port k at [k*IN_W +: IN_W]
//   OUT_PORTS  output register contents, register j at [j*OUT_W +: OUT_W]
//   INTR       registered |(pending & mask)
// -----------------------------------------------------------------------------
module mmio_port_bank #(
  parameter int unsigned N_IN        = 2,
  parameter int unsigned N_OUT       = 2,
  parameter int unsigned IN_W        = 16,
  parameter int unsigned OUT_W       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h1100_0000,
  parameter int unsigned STRIDE_LOG2 = 18
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [31:0]             IOBUS_ADDR,
  input  logic [31:0]             IOBUS_OUT,
  input  logic                    IOBUS_WR,
  output logic [31:0]             IOBUS_IN,
  input  logic [N_IN*IN_W-1:0]    IN_PORTS,
  output logic [N_OUT*OUT_W-1:0]  OUT_PORTS,
  output logic                    INTR
);

  localparam int unsigned N_REGS   = N_IN + N_OUT + 2;
  localparam int unsigned IDX_PEND = N_IN + N_OUT;
  localparam int unsigned IDX_MASK = N_IN + N_OUT + 1;
  // Bits of the offset that must be zero for an aligned access.
  localparam logic [31:0] LOW_MASK =
    (STRIDE_LOG2 == 0) ? 32'h0 : (32'hFFFF_FFFF >> (32 - STRIDE_LOG2));

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (N_IN < 1 || N_IN > 16) begin : g_bad_n_in
    $error("mmio_port_bank: N_IN must be in 1..16");
  end
  if (N_OUT < 1 || N_OUT > 16) begin : g_bad_n_out
    $error("mmio_port_bank: N_OUT must be in 1..16");
  end
  if (IN_W < 1 || IN_W > 32) begin : g_bad_in_w
    $error("mmio_port_bank: IN_W must be in 1..32");
  end
  if (OUT_W < 1 || OUT_W > 32) begin : g_bad_out_w
    $error("mmio_port_bank: OUT_W must be in 1..32");
  end
  if (STRIDE_LOG2 > 31) begin : g_bad_stride
    $error("mmio_port_bank: STRIDE_LOG2 must be in 0..31");
  end else if (64'(N_REGS) > (64'd1 << (32 - STRIDE_LOG2))) begin : g_bad_span
    $error("mmio_port_bank: register map does not fit in the address space");
  end

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [31:0]       offset;
  logic [31:0]       reg_idx;
  logic              hit;
  logic [N_REGS-1:0] sel;

  // The >= test keeps addresses below BASE_ADDR from wrapping into the map.
  assign offset  = IOBUS_ADDR - BASE_ADDR;
  assign reg_idx = offset >> STRIDE_LOG2;
  assign hit     = (IOBUS_ADDR >= BASE_ADDR) &&
                   ((offset & LOW_MASK) == 32'h0) &&
                   (reg_idx < N_REGS);

  for (genvar r = 0; r < N_REGS; r++) begin : g_sel
    assign sel[r] = hit && (reg_idx == 32'(r));
  end

  // ---------------------------------------------------------------------------
  // Input synchroniser and history
  // ---------------------------------------------------------------------------
  logic [N_IN*IN_W-1:0] s1_q, s2_q, s3_q;
  logic [N_IN-1:0]      chg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbour; blocking here would
      // collapse the s1 -> s2 -> s3 chain into a single stage.
      s1_q <= IN_PORTS;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  for (genvar k = 0; k < N_IN; k++) begin : g_chg
    assign chg[k] = |(s2_q[k*IN_W +: IN_W] ^ s3_q[k*IN_W +: IN_W]);
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] out_q [N_OUT];

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    // NOTE: unlike a RAM, this register bank is reset: the pins it drives
    // must come up at a known value.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        out_q[j] <= '0;
      end else if (IOBUS_WR && sel[N_IN + j]) begin
        out_q[j] <= IOBUS_OUT[OUT_W-1:0];
      end
    end
    assign OUT_PORTS[j*OUT_W +: OUT_W] = out_q[j];
  end

  // ---------------------------------------------------------------------------
  // Interrupt state: arm counter, pending, mask, INTR
  // ---------------------------------------------------------------------------
  logic [1:0]      arm_q, arm_d;
  logic            armed;
  logic [N_IN-1:0] pend_q, pend_d;
  logic [N_IN-1:0] mask_q, mask_d;
  logic [N_IN-1:0] pend_set, pend_clr;
  logic            intr_q, intr_d;

  // The arm counter blanks change detection while the sync chain fills
  // after reset, so inputs already high at release do not raise interrupts.
  assign armed = (arm_q == 2'd3);

  always_comb begin
    // NOTE: every output of this block gets its default first, so no path
    // through the conditionals can infer a latch.
    arm_d    = arm_q;
    mask_d   = mask_q;
    pend_set = '0;
    pend_clr = '0;

    if (!armed) begin
      arm_d = arm_q + 2'd1;
    end else begin
      pend_set = chg;
    end

    if (IOBUS_WR && sel[IDX_PEND]) begin
      pend_clr = IOBUS_OUT[N_IN-1:0];
    end
    if (IOBUS_WR && sel[IDX_MASK]) begin
      mask_d = IOBUS_OUT[N_IN-1:0];
    end

    // A set on the same edge as a W1C wins, so no edge is ever lost.
    pend_d = (pend_q & ~pend_clr) | pend_set;
    intr_d = |(pend_q & mask_q);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      arm_q  <= 2'd0;
      pend_q <= '0;
      mask_q <= '0;
      intr_q <= 1'b0;
    end else begin
      arm_q  <= arm_d;
      pend_q <= pend_d;
      mask_q <= mask_d;
      intr_q <= intr_d;
    end
  end

  assign INTR = intr_q;

  // ---------------------------------------------------------------------------
  // Read mux: each register contributes its zero-extended value when selected.
  // ---------------------------------------------------------------------------
  logic [31:0] rd_vals [N_REGS];
  logic [31:0] rd_or   [N_REGS+1];

  for (genvar k = 0; k < N_IN; k++) begin : g_rd_in
    assign rd_vals[k] = 32'(s2_q[k*IN_W +: IN_W]);
  end
  for (genvar j = 0; j < N_OUT; j++) begin : g_rd_out
    assign rd_vals[N_IN + j] = 32'(out_q[j]);
  end
  assign rd_vals[IDX_PEND] = 32'(pend_q);
  assign rd_vals[IDX_MASK] = 32'(mask_q);

  assign rd_or[0] = 32'h0;
  for (genvar r = 0; r < N_REGS; r++) begin : g_rd_or
    assign rd_or[r+1] = rd_or[r] | (sel[r] ? rd_vals[r] : 32'h0);
  end
  assign IOBUS_IN = rd_or[N_REGS];

  // Only the low bits of the write data reach any register.
  logic unused_wdata;
  assign unused_wdata = ^IOBUS_OUT;

endmodule

// File: tb/tb_mmio_port_bank.sv
// -----------------------------------------------------------------------------
// tb_mmio_port_bank
//
// Directed testbench for mmio_port_bank with default parameters
// (2 input ports x 16 bits, 2 output registers x 16 bits, base 0x1100_0000,
// stride 2^18). Inputs change on the falling edge; outputs are sampled on the
// falling edge (plus a small settle delay for combinational reads).
// -----------------------------------------------------------------------------
module tb_mmio_port_bank;

  localparam logic [31:0] A_IN0  = 32'h1100_0000;
  localparam logic [31:0] A_IN1  = 32'h1104_0000;
  localparam logic [31:0] A_OUT0 = 32'h1108_0000;
  localparam logic [31:0] A_OUT1 = 32'h110C_0000;
  localparam logic [31:0] A_PEND = 32'h1110_0000;
  localparam logic [31:0] A_MASK = 32'h1114_0000;
  localparam logic [31:0] A_NONE = 32'h1118_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] iobus_in;
  logic [31:0] in_ports;
  logic [31:0] out_ports;
  logic        intr;

  int n_checks = 0;
  int n_errors = 0;

  mmio_port_bank dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .IOBUS_ADDR (iobus_addr),
    .IOBUS_OUT  (iobus_out),
    .IOBUS_WR   (iobus_wr),
    .IOBUS_IN   (iobus_in),
    .IN_PORTS   (in_ports),
    .OUT_PORTS  (out_ports),
    .INTR       (intr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Combinational read: drive the address and sample after a short settle.
  task automatic peek(input logic [31:0] addr, output logic [31:0] data);
    iobus_addr = addr;
    #1;
    data = iobus_in;
  endtask

  // One-cycle write; returns on the falling edge after the write edge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    iobus_addr = addr;
    iobus_out  = data;
    iobus_wr   = 1'b1;
    @(negedge clk);
    iobus_wr   = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    iobus_addr = A_NONE;
    iobus_out  = 32'h0;
    iobus_wr   = 1'b0;
    in_ports   = 32'h0;

    // ---- 1. Reset and decode -------------------------------------------
    repeat (3) @(negedge clk);
    check("rst_intr_in_reset", 32'(intr), 32'h0);
    check("rst_out_in_reset", out_ports, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    peek(A_OUT0, rd); check("rst_rd_out0", rd, 32'h0);
    peek(A_OUT1, rd); check("rst_rd_out1", rd, 32'h0);
    peek(A_MASK, rd); check("rst_rd_mask", rd, 32'h0);
    peek(A_NONE, rd); check("rst_rd_unmapped", rd, 32'h0);
    peek(A_PEND, rd); check("rst_rd_pend", rd, 32'h0);
    check("rst_out_ports", out_ports, 32'h0);
    check("rst_intr", 32'(intr), 32'h0);

    // ---- 2. Output registers and unmapped addresses --------------------
    bus_write(A_OUT0, 32'hDEAD_BEEF);
    bus_write(A_OUT1, 32'h0000_1234);
    bus_write(32'h1100_0004, 32'h0000_FFFF);  // misaligned
    bus_write(32'h10FC_0000, 32'h0000_FFFF);  // below base
    bus_write(32'h1108_0004, 32'h0000_FFFF);  // misaligned inside out0 slot
    bus_write(A_IN0, 32'h0000_AAAA);          // read-only port
    bus_write(A_NONE, 32'h0000_FFFF);         // index past the map
    check("out_ports_packed", out_ports, 32'h1234_BEEF);
    peek(A_OUT0, rd); check("rd_out0", rd, 32'h0000_BEEF);
    peek(A_OUT1, rd); check("rd_out1", rd, 32'h0000_1234);
    peek(32'h1108_0004, rd); check("rd_misaligned", rd, 32'h0);
    peek(32'h10FC_0000, rd); check("rd_below_base", rd, 32'h0);
    peek(A_IN0, rd); check("rd_in0_after_ro_write", rd, 32'h0);
    peek(A_PEND, rd); check("rd_pend_after_ignored", rd, 32'h0);
    peek(A_MASK, rd); check("rd_mask_after_ignored", rd, 32'h0);

    // ---- 3. Input latency and interrupt --------------------------------
    bus_write(A_MASK, 32'h1);
    peek(A_MASK, rd); check("rd_mask_1", rd, 32'h1);
    in_ports = 32'h0000_0001;  // changes just after edge t
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      peek(A_IN0, rd);
      check($sformatf("lat_in0_e%0d", e), rd, 32'(e >= 2));
      peek(A_PEND, rd);
      check($sformatf("lat_pend_e%0d", e), rd, 32'(e >= 3));
      check($sformatf("lat_intr_e%0d", e), 32'(intr), 32'(e >= 4));
    end
    bus_write(A_PEND, 32'h1);
    peek(A_PEND, rd); check("w1c_pend", rd, 32'h0);
    @(negedge clk);
    check("w1c_intr", 32'(intr), 32'h0);
    peek(A_IN0, rd); check("w1c_in0_held", rd, 32'h1);

    // ---- 4. Set/clear collision on bit 1 -------------------------------
    in_ports = 32'h0001_0001;   // port 1 changes just after edge t
    @(negedge clk);             // edge t+1
    bus_write(A_PEND, 32'h2);   // write lands on edge t+3 with the set
    peek(A_PEND, rd); check("collision_pend", rd, 32'h2);
    @(negedge clk);
    check("collision_intr_masked", 32'(intr), 32'h0);

    // ---- 5. Masking ----------------------------------------------------
    bus_write(A_MASK, 32'h0);
    bus_write(A_PEND, 32'h2);
    peek(A_PEND, rd); check("mask_pend_cleared", rd, 32'h0);
    in_ports = 32'h0000_0001;   // port 1 falls back to 0
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      check($sformatf("masked_intr_e%0d", e), 32'(intr), 32'h0);
    end
    peek(A_PEND, rd); check("masked_pend", rd, 32'h2);
    peek(A_IN1, rd); check("rd_in1", rd, 32'h0);
    bus_write(A_MASK, 32'h2);
    check("unmask_intr_same_edge", 32'(intr), 32'h0);
    @(negedge clk);
    check("unmask_intr", 32'(intr), 32'h1);
    peek(A_MASK, rd); check("rd_mask_2", rd, 32'h2);

    // ---- 6. Reset behaviour --------------------------------------------
    @(negedge clk);
    iobus_addr = A_OUT0;
    iobus_out  = 32'h0000_5555;
    iobus_wr   = 1'b1;
    in_ports   = 32'hFFFF_FFFF;
    #2;
    rst_n = 1'b0;               // mid-cycle, before the write edge
    #1;
    check("async_rst_out", out_ports, 32'h0);
    check("async_rst_intr", 32'(intr), 32'h0);
    @(negedge clk);
    iobus_wr = 1'b0;
    check("rst_discard_write", out_ports, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      peek(A_PEND, rd);
      check($sformatf("arm_pend_e%0d", e), rd, 32'h0);
    end
    check("arm_intr", 32'(intr), 32'h0);
    peek(A_IN0, rd); check("post_rst_in0", rd, 32'h0000_FFFF);
    peek(A_IN1, rd); check("post_rst_in1", rd, 32'h0000_FFFF);
    peek(A_OUT0, rd); check("post_rst_out0", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
